// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types, colour constants and the one-hot helper for rgb_pwm_driver.
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SHOW   = 2'd2
  } state_t;

  // Bit order {r, g, b}
  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_OFF = 3'b000;
  localparam rgb_t RGB_R   = 3'b100;
  localparam rgb_t RGB_G   = 3'b010;
  localparam rgb_t RGB_B   = 3'b001;

  function automatic logic one_hot(rgb_t c);
    return (c == RGB_R) || (c == RGB_G) || (c == RGB_B);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM counter; duty is captured only at the wrap so a
// period never mixes two duty values.
module pwm_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_on_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_q;
  logic             wrap;

  assign wrap = (cnt_q == {CNT_W{1'b1}});

  // Counter advances every clock; duty reloads on the wrapping edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (wrap) begin
        duty_q <= duty_i;
      end
    end
  end

  // Duty 0 never turns on; max duty is on for all but one clock per period
  assign pwm_on_o = (cnt_q < duty_q);

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: synchronises the comparator's red/green/blue flags, filters
// glitches, latches a stable colour and drives the RGB LED pins through PWM.
// Optional build macro ERR_BLINK_EN: while err is high all three LEDs blink
// white (PWM-gated) from a BLINK_W-bit divider; otherwise they stay dark.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned BLINK_W       = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red_i,
  input  logic             green_i,
  input  logic             blue_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             color_valid,
  output logic             err,
  output logic             changed
);

  localparam int unsigned StabW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);

  rgb_t             sync1_q, sync2_q, raw;
  state_t           state_q, state_d;
  rgb_t             cand_q, cand_d;
  rgb_t             shown_q, shown_d;
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  // Set at the first latch after reset; keeps all outputs dark until then
  logic             latched_q, latched_d;

  rgb_t             led_q, led_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             changed_q, changed_d;

  logic             pwm_on;
  logic             show_ok;
  logic             shown_oh;

  // Two-flop synchroniser for the asynchronous comparator flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= RGB_OFF;
      sync2_q <= RGB_OFF;
    end else begin
      sync1_q <= {red_i, green_i, blue_i};
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q;

  pwm_gen #(
    .CNT_W (CNT_W)
  ) u_pwm_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty_i   (duty_i),
    .pwm_on_o (pwm_on)
  );

`ifdef ERR_BLINK_EN
  logic [BLINK_W-1:0] blink_q;

  // Free-running divider whose MSB sets the error blink rate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + BLINK_W'(1);
    end
  end
`else
  logic unused_blink_w;
  assign unused_blink_w = ^BLINK_W;
`endif

  // Filter state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cand_q     <= RGB_OFF;
      shown_q    <= RGB_OFF;
      stab_cnt_q <= '0;
      latched_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      shown_q    <= shown_d;
      stab_cnt_q <= stab_cnt_d;
      latched_q  <= latched_d;
    end
  end

  // Filter next state: any change of raw restarts the stability count
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    shown_d    = shown_q;
    stab_cnt_d = stab_cnt_q;
    latched_d  = latched_q;
    unique case (state_q)
      IDLE: begin
        cand_d     = raw;
        stab_cnt_d = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (raw != cand_q) begin
          cand_d     = raw;
          stab_cnt_d = '0;
        end else if (stab_cnt_q != StabLast) begin
          stab_cnt_d = stab_cnt_q + StabW'(1);
        end else begin
          shown_d   = cand_q;
          latched_d = 1'b1;
          state_d   = SHOW;
        end
      end
      SHOW: begin
        if (raw != cand_q) begin
          cand_d     = raw;
          stab_cnt_d = '0;
          state_d    = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from next-state values so registered outputs align with shown
  always_comb begin
    show_ok   = latched_d && (state_d != IDLE);
    shown_oh  = one_hot(shown_d);
    led_d     = RGB_OFF;
    valid_d   = show_ok && shown_oh;
    err_d     = show_ok && !shown_oh;
    changed_d = (shown_d != shown_q);
    if (valid_d) begin
      led_d = shown_d & {3{pwm_on}};
    end
`ifdef ERR_BLINK_EN
    if (err_d) begin
      led_d = {3{blink_q[BLINK_W-1] & pwm_on}};
    end
`endif
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q     <= RGB_OFF;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      changed_q <= changed_d;
    end
  end

  assign led_r       = led_q[2];
  assign led_g       = led_q[1];
  assign led_b       = led_q[0];
  assign color_valid = valid_q;
  assign err         = err_q;
  assign changed     = changed_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed and randomised stimulus checked every clock
// against a behavioural model of the filter, PWM and output rules.
module tb_rgb_pwm_driver;

  localparam int CNT_W  = 4;
  localparam int STABLE = 4;
  localparam int BLINK_W = 6;
  localparam int PERIOD = 1 << CNT_W;

  logic             clk;
  logic             rst_n;
  logic [2:0]       flags;
  logic [CNT_W-1:0] duty;
  logic             led_r, led_g, led_b, color_valid, err, changed;

  int n_tests;
  int n_fail;

  // Model state
  int       e;          // released edges since last reset
  bit [2:0] d1, d2;     // two-clock input delay
  bit [2:0] run_val;
  int       run_len;
  bit [2:0] shown_m;
  bit       latched_m;
  bit       chg_m;
  int       duty_m;

  rgb_pwm_driver #(
    .CNT_W         (CNT_W),
    .STABLE_CYCLES (STABLE),
    .BLINK_W       (BLINK_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .red_i       (flags[2]),
    .green_i     (flags[1]),
    .blue_i      (flags[0]),
    .duty_i      (duty),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .color_valid (color_valid),
    .err         (err),
    .changed     (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // One clock: advance the model by the spec's rules, then compare all outputs.
  task automatic tick();
    int       cnt_pre;
    bit       pwm_pre;
    bit [2:0] r;
    bit [2:0] exp_led;
    bit       exp_v, exp_e;
`ifdef ERR_BLINK_EN
    bit       blink_pre;
    blink_pre = ((e % (1 << BLINK_W)) >= (1 << (BLINK_W - 1)));
`endif
    cnt_pre = e % PERIOD;
    pwm_pre = (cnt_pre < duty_m);
    r = d2;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      e = 0; d1 = 0; d2 = 0; run_val = 0; run_len = 0;
      shown_m = 0; latched_m = 0; chg_m = 0; duty_m = 0;
    end else begin
      e++;
      chg_m = 0;
      if (e == 1 || r != run_val) begin
        run_val = r;
        run_len = 0;
      end else begin
        run_len++;
      end
      if (run_len == STABLE) begin
        chg_m = (r != shown_m);
        shown_m = r;
        latched_m = 1;
      end
      if (cnt_pre == PERIOD - 1) duty_m = int'(duty);
      d2 = d1;
      d1 = flags;
    end
    exp_v = latched_m && ($countones(shown_m) == 1);
    exp_e = latched_m && ($countones(shown_m) != 1);
    exp_led = exp_v ? (shown_m & {3{pwm_pre}}) : 3'b000;
`ifdef ERR_BLINK_EN
    if (exp_e) exp_led = {3{pwm_pre & blink_pre}};
`endif
    check("leds", int'({led_r, led_g, led_b}), int'(exp_led));
    check("color_valid", int'(color_valid), int'(exp_v));
    check("err", int'(err), int'(exp_e));
    check("changed", int'(changed), int'(chg_m));
  endtask

  initial begin
    int lat;
    int cnt;
    bit found;
    n_tests = 0;
    n_fail = 0;
    e = 0; d1 = 0; d2 = 0; run_val = 0; run_len = 0;
    shown_m = 0; latched_m = 0; chg_m = 0; duty_m = 0;

    // Reset held with red asserted
    rst_n = 1'b0;
    flags = 3'b100;
    duty = 4'd4;
    repeat (3) tick();

    // Release: colour must latch on the 7th released edge
    rst_n = 1'b1;
    lat = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      lat++;
      if (color_valid) found = 1;
    end
    check("reset_latency", lat, 7);
    check("first_changed", int'(changed), 1);

    // PWM ratio with duty 4 once loaded
    repeat (30) tick();
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      cnt += int'(led_r);
    end
    check("duty4_window", cnt, 4);

    // Stable switch to green
    flags = 3'b010;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(changed);
    end
    check("switch_changed_count", cnt, 1);

    // Short glitch to blue must not change the shown colour
    flags = 3'b001;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(changed);
    end
    flags = 3'b010;
    for (int i = 0; i < 12; i++) begin
      tick();
      cnt += int'(changed);
    end
    check("glitch_changed_count", cnt, 0);

    // Duty change mid-period, then full-off
    repeat (5) tick();
    duty = 4'd12;
    repeat (40) tick();
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      cnt += int'(led_g);
    end
    check("duty12_window", cnt, 12);
    duty = 4'd0;
    repeat (40) tick();
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      cnt += int'(led_g);
    end
    check("duty0_window", cnt, 0);

    // Non-one-hot colour
    duty = 4'd9;
    flags = 3'b110;
    repeat (40) tick();
    check("nonhot_err", int'(err), 1);
    check("nonhot_valid", int'(color_valid), 0);

    // Reset two clocks into a change, then recovery timing
    flags = 3'b001;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lat = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      lat++;
      if (color_valid) found = 1;
    end
    check("midreset_latency", lat, 7);

    // Randomised flags, hold lengths and duty
    for (int k = 0; k < 200; k++) begin
      int pick;
      int hold;
      pick = $urandom_range(0, 5);
      if (pick < 3) flags = 3'b100 >> pick;
      else flags = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) duty = 4'($urandom_range(0, PERIOD - 1));
      if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
      hold = $urandom_range(1, 8);
      repeat (hold) tick();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the 2-bit comparator, which produces one-hot red/green/blue flags.
- Synchronises the three flags, glitch-filters them, and latches a stable colour.
- Drives the board RGB LED pins with a programmable-brightness PWM.
- Reports an error when the comparator result is not one-hot.

Parameters:
CNT_W, 8, PWM counter width; PWM period = 2**CNT_W clocks
STABLE_CYCLES, 16, consecutive clocks a synchronised colour must hold before latching (>=1)
BLINK_W, 24, error-blink divider width (used only with ERR_BLINK_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
red_i  in  1  comparator flag a>b (asynchronous to clk)
green_i  in  1  comparator flag a==b (asynchronous)
blue_i  in  1  comparator flag a<b (asynchronous)
duty_i  in  CNT_W  brightness; on-clocks per PWM period
led_r  out  1  PWM-gated red drive
led_g  out  1  PWM-gated green drive
led_b  out  1  PWM-gated blue drive
color_valid  out  1  high while the latched colour is one-hot and displayed
err  out  1  high while the latched colour is not one-hot (000, or 2+ bits set)
changed  out  1  one-clock pulse when the latched colour takes a new value

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs, sync flops, cand, shown, stab_cnt, pwm_cnt and duty_q go to 0; state goes to IDLE.
  - Reset asserted mid-operation aborts immediately, with no partial update.
- Synchroniser:
  - 2-flop chain per flag; raw = {red,green,blue} after the second flop.
  - Adds 2 clocks latency.
- Filter FSM, states IDLE, SETTLE, SHOW:
  - IDLE: on the first edge after reset, cand<=raw, stab_cnt<=0, go to SETTLE.
  - SETTLE, raw!=cand: cand<=raw, stab_cnt<=0, stay in SETTLE.
  - SETTLE, raw==cand and stab_cnt<STABLE_CYCLES-1: stab_cnt++.
  - SETTLE, raw==cand and stab_cnt==STABLE_CYCLES-1: shown<=cand, go to SHOW. changed=1 on the following cycle iff the new shown differs from the old shown.
  - SHOW, raw!=cand: cand<=raw, stab_cnt<=0, go to SETTLE. shown is held, and the LEDs keep displaying it during SETTLE.
- Total latency from an input change to shown: 2 (synchroniser) + 1 (capture) + STABLE_CYCLES clocks.
- Any input glitch shorter than STABLE_CYCLES leaves shown unchanged.
- PWM:
  - pwm_cnt is free-running 0..2**CNT_W-1 and wraps to 0.
  - duty_q<=duty_i only on the edge where pwm_cnt wraps, so a period never glitches.
  - pwm_on = (pwm_cnt < duty_q). duty 0 means always off; max duty means on for 2**CNT_W-1 of 2**CNT_W clocks.
- Outputs (all registered):
  - led_x = shown[x] & pwm_on & one_hot(shown) & (state!=IDLE).
  - color_valid = one_hot(shown) & (state!=IDLE).
  - err = !one_hot(shown) & (state!=IDLE). err and color_valid are mutually exclusive.
  - After reset, led_*, color_valid and err stay 0 until the first latch.

Optional Feature:
ERR_BLINK_EN:
- Defined: a BLINK_W-bit free-running counter is added. While err=1, all three LEDs are driven by blink_cnt[BLINK_W-1] & pwm_on (white blink).
- Undefined: the counter is absent and LEDs are 0 while err=1.
- color_valid, err and changed behave identically either way.

Decomposition:
- Package rgb_pkg: enum state_t {IDLE, SETTLE, SHOW}; typedef logic [2:0] rgb_t (bit order r,g,b); constants RGB_OFF=3'b000, RGB_R=3'b100, RGB_G=3'b010, RGB_B=3'b001; function one_hot(rgb_t).
- One natural sub-module: pwm_gen (counter, duty_q capture, pwm_on).
- Synchroniser and FSM stay in the top module.

Test Plan (CNT_W=4, STABLE_CYCLES=4 unless noted):
- Reset: hold rst_n=0 for 3 clocks with flags=100 -> all outputs 0. Release -> shown=100 and color_valid=1 exactly 7 clocks after the first released edge; changed pulses once.
- Stable switch: 100->010 held -> changed pulses once 7 clocks later, led_r stops, led_g toggles with PWM.
- Glitch: 010->001 for 3 clocks, then back to 010 -> shown stays 010, changed never asserts.
- PWM: duty_i=4 -> led on for exactly 4 of every 16 clocks. duty_i changed to 12 mid-period -> the new ratio starts at the next wrap. duty_i=0 -> led constantly 0.
- Non-one-hot: flags=110 held -> err=1, color_valid=0, LEDs 0. With ERR_BLINK_EN and BLINK_W=6: all LEDs PWM-gated on for 32 clocks, then off for 32 clocks.
- Reset mid-SETTLE: assert rst_n=0 two clocks into a change -> outputs 0 on the next edge, and recovery repeats the first scenario's timing.
